telemetry_rx: RTL and testbench

- Receive-side counterpart of the telemetry transmitter. Takes the serial telemetry stream on one line and deserializes 8N1 UART bytes.
- Locks onto the 0xAA, 0x55 delimiter pair and collects the six payload bytes, then presents batt_v, avg_curr and avg_torque as registered 12-bit words with a one-cycle valid strobe.
- Sits at the host/bench end of the telemetry link and also serves as the loopback checker for the transmitter.

---
 rtl/telemetry_rx.sv | 180 ++++++++++++++++++
 tb/tb_telemetry_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_rx.sv
// Telemetry link receiver: 8N1 UART deserializer plus a frame parser that locks on
// the 0xAA 0x55 delimiter and publishes three 12-bit words with a one-cycle strobe.
module telemetry_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic [11:0] batt_v,
    output logic [11:0] avg_curr,
    output logic [11:0] avg_torque,
    output logic        frm_vld,
    output logic        frm_err,
    output logic [1:0]  dbg_byte_state,
    output logic [2:0]  dbg_parse_state
);

    localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} byte_state_t;
    typedef enum logic [2:0] {HUNT, GOT_AA, PAY0, PAY1, PAY2, PAY3, PAY4, PAY5} parse_state_t;

    logic         rx_meta_q, rx_s_q;
    byte_state_t  bstate_q, bstate_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [2:0]   bit_q, bit_d;
    logic [7:0]   shreg_q, shreg_d;
    logic         byte_rdy_q, byte_rdy_d;
    logic         stop_err_q, stop_err_d;

    parse_state_t pstate_q, pstate_d;
    logic [11:0]  sh_batt_q, sh_batt_d, sh_curr_q, sh_curr_d, sh_torq_q, sh_torq_d;
    logic [11:0]  batt_q, batt_d, curr_q, curr_d, torq_q, torq_d;
    logic         vld_q, vld_d, err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            bstate_q   <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            byte_rdy_q <= 1'b0;
            stop_err_q <= 1'b0;
            pstate_q   <= HUNT;
            sh_batt_q  <= '0;
            sh_curr_q  <= '0;
            sh_torq_q  <= '0;
            batt_q     <= '0;
            curr_q     <= '0;
            torq_q     <= '0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rx_meta_q  <= RX;
            rx_s_q     <= rx_meta_q;
            bstate_q   <= bstate_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            byte_rdy_q <= byte_rdy_d;
            stop_err_q <= stop_err_d;
            pstate_q   <= pstate_d;
            sh_batt_q  <= sh_batt_d;
            sh_curr_q  <= sh_curr_d;
            sh_torq_q  <= sh_torq_d;
            batt_q     <= batt_d;
            curr_q     <= curr_d;
            torq_q     <= torq_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
        end
    end

    // Byte FSM: every sample is taken at mid-bit, counted from the mid-start point.
    always_comb begin
        bstate_d   = bstate_q;
        cnt_d      = cnt_q + 16'd1;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        byte_rdy_d = 1'b0;
        stop_err_d = 1'b0;
        case (bstate_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) bstate_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        bstate_d = DATA;
                        bit_d    = '0;
                    end else begin
                        bstate_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    if (bit_q == 3'd7) bstate_d = STOP;
                    else               bit_d    = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    bstate_d   = IDLE;
                    byte_rdy_d = rx_s_q;
                    stop_err_d = !rx_s_q;
                end
            end
            default: bstate_d = IDLE;
        endcase
    end

    // Parser: shreg_q still holds the completed byte while byte_rdy_q is high.
    always_comb begin
        pstate_d  = pstate_q;
        sh_batt_d = sh_batt_q;
        sh_curr_d = sh_curr_q;
        sh_torq_d = sh_torq_q;
        batt_d    = batt_q;
        curr_d    = curr_q;
        torq_d    = torq_q;
        vld_d     = 1'b0;
        err_d     = 1'b0;
        if (stop_err_q) begin
            err_d    = 1'b1;
            pstate_d = HUNT;
        end else if (byte_rdy_q) begin
            case (pstate_q)
                HUNT:   if (shreg_q == 8'hAA) pstate_d = GOT_AA;
                GOT_AA: begin
                    if (shreg_q == 8'h55)      pstate_d = PAY0;
                    else if (shreg_q != 8'hAA) pstate_d = HUNT;
                end
                PAY0, PAY2, PAY4: begin
                    if (shreg_q[7:4] != 4'h0) begin
                        err_d    = 1'b1;
                        pstate_d = HUNT;
                    end else begin
                        if (pstate_q == PAY0)      sh_batt_d[11:8] = shreg_q[3:0];
                        else if (pstate_q == PAY2) sh_curr_d[11:8] = shreg_q[3:0];
                        else                       sh_torq_d[11:8] = shreg_q[3:0];
                        pstate_d = parse_state_t'(pstate_q + 3'd1);
                    end
                end
                PAY1: begin
                    sh_batt_d[7:0] = shreg_q;
                    pstate_d       = PAY2;
                end
                PAY3: begin
                    sh_curr_d[7:0] = shreg_q;
                    pstate_d       = PAY4;
                end
                PAY5: begin
                    batt_d   = sh_batt_q;
                    curr_d   = sh_curr_q;
                    torq_d   = {sh_torq_q[11:8], shreg_q};
                    vld_d    = 1'b1;
                    pstate_d = HUNT;
                end
                default: pstate_d = HUNT;
            endcase
        end
    end

    assign batt_v          = batt_q;
    assign avg_curr        = curr_q;
    assign avg_torque      = torq_q;
    assign frm_vld         = vld_q;
    assign frm_err         = err_q;
    assign dbg_byte_state  = bstate_q;
    assign dbg_parse_state = pstate_q;

endmodule

// File: tb/tb_telemetry_rx.sv
// Directed bench for telemetry_rx at BAUD_DIV = 16: frames, resync, format and
// framing errors, start-bit glitch and mid-frame reset.
module tb_telemetry_rx;
    localparam int BAUD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX  = 1'b1;
    logic [11:0] batt_v, avg_curr, avg_torque;
    logic        frm_vld, frm_err;
    logic [1:0]  dbg_byte_state;
    logic [2:0]  dbg_parse_state;

    int checks = 0;
    int passed = 0;
    int vld_total = 0;
    int err_total = 0;
    int both_total = 0;

    telemetry_rx #(.BAUD_DIV(BAUD)) dut (
        .clk(clk), .rst(rst), .RX(RX),
        .batt_v(batt_v), .avg_curr(avg_curr), .avg_torque(avg_torque),
        .frm_vld(frm_vld), .frm_err(frm_err),
        .dbg_byte_state(dbg_byte_state), .dbg_parse_state(dbg_parse_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frm_vld) vld_total++;
        if (frm_err) err_total++;
        if (frm_vld && frm_err) both_total++;
    end

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        RX = v;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic send_frame(input logic [7:0] f [8]);
        for (int i = 0; i < 8; i++) send_byte(f[i], 1'b1);
    endtask

    task automatic check_counts(input string name, input int v0, input int e0,
                                input int exp_v, input int exp_e);
        checks++;
        if ((vld_total - v0) !== exp_v) $display("FAIL %s frm_vld count got %0d want %0d", name, vld_total - v0, exp_v);
        else passed++;
        checks++;
        if ((err_total - e0) !== exp_e) $display("FAIL %s frm_err count got %0d want %0d", name, err_total - e0, exp_e);
        else passed++;
    endtask

    task automatic check_outs(input string name, input logic [11:0] b, input logic [11:0] c,
                              input logic [11:0] t);
        checks++;
        if (batt_v !== b) $display("FAIL %s batt_v got %h want %h", name, batt_v, b);
        else passed++;
        checks++;
        if (avg_curr !== c) $display("FAIL %s avg_curr got %h want %h", name, avg_curr, c);
        else passed++;
        checks++;
        if (avg_torque !== t) $display("FAIL %s avg_torque got %h want %h", name, avg_torque, t);
        else passed++;
    endtask

    task automatic test_reset();
        int v0, e0;
        rst = 1'b1;
        RX  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        v0 = vld_total;
        e0 = err_total;
        idle(1000);
        check_outs("reset", 12'h000, 12'h000, 12'h000);
        check_counts("reset", v0, e0, 0, 0);
        checks++;
        if (dbg_byte_state !== 2'd0) $display("FAIL reset byte_state got %0d want 0", dbg_byte_state);
        else passed++;
        checks++;
        if (dbg_parse_state !== 3'd0) $display("FAIL reset parse_state got %0d want 0", dbg_parse_state);
        else passed++;
    endtask

    task automatic test_good_frame();
        int v0, e0;
        v0 = vld_total;
        e0 = err_total;
        send_frame('{8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h03, 8'h21, 8'h0F, 8'hFF});
        idle(8);
        check_counts("good_frame", v0, e0, 1, 0);
        check_outs("good_frame", 12'hABC, 12'h321, 12'hFFF);
    endtask

    task automatic test_format_err();
        int v0, e0;
        v0 = vld_total;
        e0 = err_total;
        send_frame('{8'hAA, 8'h55, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        idle(8);
        check_counts("format_err", v0, e0, 0, 1);
        check_outs("format_err_hold", 12'hABC, 12'h321, 12'hFFF);
        v0 = vld_total;
        e0 = err_total;
        send_frame('{8'hAA, 8'h55, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03});
        idle(8);
        check_counts("after_format_err", v0, e0, 1, 0);
        check_outs("after_format_err", 12'h001, 12'h002, 12'h003);
    endtask

    task automatic test_resync();
        int v0, e0;
        logic [7:0] seq [10];
        seq = '{8'h12, 8'hAA, 8'hAA, 8'h55, 8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89};
        v0 = vld_total;
        e0 = err_total;
        for (int i = 0; i < 10; i++) send_byte(seq[i], 1'b1);
        idle(8);
        check_counts("resync", v0, e0, 1, 0);
        check_outs("resync", 12'h123, 12'h456, 12'h789);
    endtask

    task automatic test_stop_err();
        int v0, e0;
        v0 = vld_total;
        e0 = err_total;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b0);
        idle(3 * BAUD);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        check_counts("stop_err", v0, e0, 0, 1);
        check_outs("stop_err_hold", 12'h123, 12'h456, 12'h789);
        v0 = vld_total;
        e0 = err_total;
        send_frame('{8'hAA, 8'h55, 8'h05, 8'h5A, 8'h06, 8'h6B, 8'h07, 8'h7C});
        idle(8);
        check_counts("after_stop_err", v0, e0, 1, 0);
        check_outs("after_stop_err", 12'h55A, 12'h66B, 12'h77C);
    endtask

    task automatic test_glitch();
        int v0, e0;
        v0 = vld_total;
        e0 = err_total;
        RX = 1'b0;
        repeat (4) @(negedge clk);
        idle(4 * BAUD);
        check_counts("glitch", v0, e0, 0, 0);
        checks++;
        if (dbg_byte_state !== 2'd0) $display("FAIL glitch byte_state got %0d want 0", dbg_byte_state);
        else passed++;
        check_outs("glitch_hold", 12'h55A, 12'h66B, 12'h77C);
    endtask

    task automatic test_mid_reset();
        int v0, e0;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h0A, 1'b1);
        send_byte(8'hBC, 1'b1);
        send_byte(8'h03, 1'b1);
        v0 = vld_total;
        e0 = err_total;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        check_outs("mid_reset", 12'h000, 12'h000, 12'h000);
        checks++;
        if (dbg_parse_state !== 3'd0) $display("FAIL mid_reset parse_state got %0d want 0", dbg_parse_state);
        else passed++;
        send_frame('{8'hAA, 8'h55, 8'h09, 8'h87, 8'h06, 8'h54, 8'h03, 8'h21});
        idle(8);
        check_counts("mid_reset_frame", v0, e0, 1, 0);
        check_outs("mid_reset_frame", 12'h987, 12'h654, 12'h321);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_format_err();
        test_resync();
        test_stop_err();
        test_glitch();
        test_mid_reset();
        checks++;
        if (both_total !== 0) $display("FAIL vld_err_overlap got %0d want 0", both_total);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end
endmodule
